// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential vedic multiplier: FSM state encoding
// and the default operand width.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/vedic_2x2.sv
// 2x2-bit vedic (urdhva tiryagbhyam) multiplier: vertical and crosswise
// partial products combined with two half adders.
module vedic_2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    logic cross_lo;
    logic cross_hi;
    logic vert_hi;
    logic carry1;

    assign cross_lo = a_i[1] & b_i[0];
    assign cross_hi = a_i[0] & b_i[1];
    assign vert_hi  = a_i[1] & b_i[1];
    assign carry1   = cross_lo & cross_hi;

    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = cross_lo ^ cross_hi;
    assign p_o[2] = vert_hi ^ carry1;
    assign p_o[3] = vert_hi & carry1;

endmodule

// File: rtl/vedic_seq_mul.sv
// Sequential unsigned multiplier: one 2x2 digit product per cycle, shifted and
// accumulated over N*N cycles, with valid/ready handshakes on both sides.
module vedic_seq_mul
    import vedic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // state | meaning
    // IDLE  | waiting for an operand pair, in_ready high
    // CALC  | accumulating one digit product per edge, idx 0..N*N-1
    // DONE  | product valid, held until out_ready

    localparam int N    = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int IDXW = (N * N > 1) ? $clog2(N * N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N * N - 1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;

    logic [IDXW-1:0]   i_idx;
    logic [IDXW-1:0]   j_idx;
    logic [1:0]        dig_a;
    logic [1:0]        dig_b;
    logic [3:0]        dig_p;
    logic [PW-1:0]     term;
    logic [PW-1:0]     sum;

    // Digit i of a pairs with digit j of b; the weight of the product is 4^(i+j).
    assign i_idx = IDXW'(idx_q % N);
    assign j_idx = IDXW'(idx_q / N);
    assign dig_a = 2'(a_q >> (2 * i_idx));
    assign dig_b = 2'(b_q >> (2 * j_idx));

    vedic_2x2 u_digit_mul (
        .a_i (dig_a),
        .b_i (dig_b),
        .p_o (dig_p)
    );

    assign term = PW'(dig_p) << (2 * (i_idx + j_idx));
    assign sum  = acc_q + term;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = sum;
                if (idx_q == LAST_IDX) begin
                    prod_d  = sum;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = prod_q;

endmodule

// File: doc/vedic_seq_mul.md
VEDIC_SEQ_MUL -- requirements
Module: vedic_seq_mul

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2; N = WIDTH/2 two-bit digits per operand.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair available.
REQ-006 in_ready  output  1  block able to accept operands.
REQ-007 a  input  WIDTH  unsigned multiplicand.
REQ-008 b  input  WIDTH  unsigned multiplier.
REQ-009 out_valid  output  1  product available.
REQ-010 out_ready  input  1  consumer accepts product.
REQ-011 product  output  2*WIDTH  unsigned a*b.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE; reset state is IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are registered-state decodes with no combinational path from inputs.
REQ-014 Accept edge = rising edge with in_valid & in_ready: latch a and b, clear the accumulator, clear the digit index, go to CALC.
REQ-015 In CALC, each edge SHALL add one 4-bit digit product a_d[i]*b_d[j], left-shifted by 2*(i+j), to a 2*WIDTH accumulator; i = idx mod N, j = idx div N; idx counts 0..N*N-1.
REQ-016 Digit products SHALL be formed by one vedic_2x2 instance fed from the latched operands.
REQ-017 On the edge that adds the product for idx = N*N-1, the block SHALL load product with the final sum, set state to DONE and reset idx to 0.
REQ-018 Latency: out_valid SHALL rise exactly N*N edges after the accept edge (16 for WIDTH=8), independent of operand values; zero operands get no early exit.
REQ-019 Accumulation SHALL be modulo 2^(2*WIDTH); the true result never exceeds that range, so no overflow flag exists.
REQ-020 In DONE, product and out_valid SHALL hold stable until an edge with out_ready=1, which returns the block to IDLE.
REQ-021 in_valid, a and b SHALL be ignored outside IDLE; a change on a or b during CALC SHALL NOT affect the result.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 Output handshake and a new input are not accepted on the same edge; minimum throughput is one result per N*N+2 cycles.
REQ-024 product SHALL retain the last result in IDLE and CALC until overwritten per REQ-017.

Reset
REQ-025 With rst=1 on an edge: state=IDLE, idx=0, accumulator=0, product=0, latched operands=0, out_valid=0, in_ready=1 after that edge.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation; the partial or pending result is discarded and no out_valid pulse follows.
REQ-027 rst SHALL take priority over both handshakes on the same edge.

Structure
REQ-028 Shared package vedic_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-029 The only sub-module SHALL be the existing vedic_2x2; digit muxing, shift, accumulator, counter and FSM are local to vedic_seq_mul.

Verification
REQ-030 a=3, b=5 accepted -> out_valid exactly 16 edges later with product=15.
REQ-031 a=255, b=255 -> product=65025 (0xFE01); a=0, b=200 -> product=0 after 16 edges.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> product and out_valid stay stable; the first out_ready=1 edge moves to IDLE with in_ready=1.
REQ-033 Reset on the 7th CALC edge of a=170, b=85 -> IDLE and product=0, with no out_valid; a new op a=12, b=12 -> 144.
REQ-034 Toggle a and b every cycle during CALC and drive in_valid=1 throughout -> the result equals the product of the latched operands, and only one accept occurs per operation.
REQ-035 Back-to-back random pairs (1000 ops, random valid and ready) -> every product matches a*b, and the accept-to-out_valid spacing is always 16.
